// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the decode-to-execute pipeline stage.
//   ctrl_t      : packed 11-bit control bundle carried from D to E
//   CTRL_WIDTH  : width of ctrl_t
//   ctrl_bubble : clears the side-effect fields (reg_write, mem_write, jump,
//                 branch) of a bundle that is not backed by a valid instruction
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_ctrl;
        logic       alu_src;
    } ctrl_t;

    localparam int CTRL_WIDTH = $bits(ctrl_t);

    // A bubble must never write the register file or memory, nor redirect fetch.
    function automatic ctrl_t ctrl_bubble(input ctrl_t ctrl, input logic valid);
        ctrl_t masked;
        masked = ctrl;
        if (!valid) begin
            masked.reg_write = 1'b0;
            masked.mem_write = 1'b0;
            masked.jump      = 1'b0;
            masked.branch    = 1'b0;
        end else begin
            masked = ctrl;
        end
        return masked;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Generic single-entry skid buffer. Holds one payload word when the downstream
// register is stalled. `ready` comes straight from a flop so the upstream
// handshake has no combinational path from downstream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush, empties the entry (wins over push/pop)
//   push       : capture din into the entry
//   pop        : release the entry (caller guarantees push and pop never overlap)
//   din / dout : payload in / stored payload
//   full       : entry occupied
//   ready      : registered complement of full
// -----------------------------------------------------------------------------
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             ready
);

    logic             full_r;
    logic             ready_r;
    logic [WIDTH-1:0] data_r;

    // Occupancy, registered ready and stored payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r  <= 1'b0;
            ready_r <= 1'b1;
            data_r  <= {WIDTH{1'b0}};
        end else if (clear) begin
            full_r  <= 1'b0;
            ready_r <= 1'b1;
        end else if (push) begin
            full_r  <= 1'b1;
            ready_r <= 1'b0;
            data_r  <= din;
        end else if (pop) begin
            full_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            full_r  <= full_r;
            ready_r <= ready_r;
        end
    end

    assign dout  = data_r;
    assign full  = full_r;
    assign ready = ready_r;

endmodule

// File: rtl/pipe_reg_de.sv
// -----------------------------------------------------------------------------
// pipe_reg_de
// Elastic decode-to-execute pipeline register with valid/ready handshake,
// flush, bubble-safe control and a saturating stall-cycle counter.
// Build option:
//   PIPE_SKID_EN : adds a one-entry skid buffer (pipe_skid_buf) so that
//                  ready_d_o is a flop output; otherwise ready_d_o is
//                  !valid_e_o || ready_e_i.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : drop the E instruction and the incoming D one
//   valid_d_i / ready_d_o  : decode-side handshake
//   *_d_i                  : decode payload (rd1, rd2, imm_ext, pc, pc_plus4,
//                            rd_addr, ctrl)
//   valid_e_o / ready_e_i  : execute-side handshake
//   *_e_o                  : registered payload; ctrl_e_o side-effect fields
//                            read 0 while valid_e_o is 0
//   stall_cnt_o            : saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_reg_de
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      valid_d_i,
    output logic                      ready_d_o,
    input  logic [DATA_WIDTH-1:0]     rd1_d_i,
    input  logic [DATA_WIDTH-1:0]     rd2_d_i,
    input  logic [DATA_WIDTH-1:0]     imm_ext_d_i,
    input  logic [ADDRESS_WIDTH-1:0]  pc_d_i,
    input  logic [ADDRESS_WIDTH-1:0]  pc_plus4_d_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_d_i,
    input  logic [CTRL_WIDTH-1:0]     ctrl_d_i,
    output logic                      valid_e_o,
    input  logic                      ready_e_i,
    output logic [DATA_WIDTH-1:0]     rd1_e_o,
    output logic [DATA_WIDTH-1:0]     rd2_e_o,
    output logic [DATA_WIDTH-1:0]     imm_ext_e_o,
    output logic [ADDRESS_WIDTH-1:0]  pc_e_o,
    output logic [ADDRESS_WIDTH-1:0]  pc_plus4_e_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_e_o,
    output logic [CTRL_WIDTH-1:0]     ctrl_e_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    localparam int PAYLOAD_W = 3 * DATA_WIDTH + 2 * ADDRESS_WIDTH
                             + REG_ADDR_WIDTH + CTRL_WIDTH;

    logic [PAYLOAD_W-1:0] payload_d_s;
    logic [PAYLOAD_W-1:0] load_data_s;
    logic [PAYLOAD_W-1:0] payload_e_r;
    logic                 valid_e_r;
    logic                 load_s;
    logic                 xfer_in_s;
    logic                 e_free_s;
    logic                 stall_s;
    logic [CNT_WIDTH-1:0] stall_cnt_r;
    ctrl_t                ctrl_e_s;

    assign payload_d_s = {rd1_d_i, rd2_d_i, imm_ext_d_i, pc_d_i, pc_plus4_d_i,
                          rd_addr_d_i, ctrl_d_i};

    assign xfer_in_s = valid_d_i && ready_d_o;
    // E can take a new word this cycle: it is empty or its word is leaving.
    assign e_free_s  = !valid_e_r || ready_e_i;
    assign stall_s   = valid_e_r && !ready_e_i && !flush_i;

`ifdef PIPE_SKID_EN
    logic [PAYLOAD_W-1:0] skid_data_s;
    logic                 skid_full_s;
    logic                 skid_ready_s;
    logic                 skid_push_s;
    logic                 skid_pop_s;

    // Incoming word parks in the skid only while E is stalled; a held skid
    // word always drains into E before anything new (ready_d_o is low then).
    assign skid_push_s = xfer_in_s && !e_free_s;
    assign skid_pop_s  = e_free_s && skid_full_s;

    pipe_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (flush_i),
        .push  (skid_push_s),
        .pop   (skid_pop_s),
        .din   (payload_d_s),
        .dout  (skid_data_s),
        .full  (skid_full_s),
        .ready (skid_ready_s)
    );

    assign ready_d_o = skid_ready_s;

    // Select E's next word: skid first to keep ordering, then decode.
    always_comb begin
        load_s      = 1'b0;
        load_data_s = payload_d_s;
        if (e_free_s) begin
            if (skid_full_s) begin
                load_s      = 1'b1;
                load_data_s = skid_data_s;
            end else if (xfer_in_s) begin
                load_s      = 1'b1;
                load_data_s = payload_d_s;
            end else begin
                load_s      = 1'b0;
            end
        end else begin
            load_s = 1'b0;
        end
    end
`else
    assign ready_d_o = e_free_s;

    // Without a skid, E loads exactly when decode hands over a word.
    always_comb begin
        load_s      = xfer_in_s;
        load_data_s = payload_d_s;
    end
`endif

    // E register: flush beats load; a free E with nothing to load empties.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_e_r   <= 1'b0;
            payload_e_r <= {PAYLOAD_W{1'b0}};
        end else if (flush_i) begin
            valid_e_r   <= 1'b0;
        end else if (load_s) begin
            valid_e_r   <= 1'b1;
            payload_e_r <= load_data_s;
        end else if (e_free_s) begin
            valid_e_r   <= 1'b0;
        end else begin
            valid_e_r   <= valid_e_r;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign ctrl_e_s = ctrl_t'(payload_e_r[CTRL_WIDTH-1:0]);

    assign {rd1_e_o, rd2_e_o, imm_ext_e_o, pc_e_o, pc_plus4_e_o, rd_addr_e_o}
               = payload_e_r[PAYLOAD_W-1:CTRL_WIDTH];
    assign ctrl_e_o    = ctrl_bubble(ctrl_e_s, valid_e_r);
    assign valid_e_o   = valid_e_r;
    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_pipe_reg_de.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_de
// Directed bench for pipe_reg_de (CNT_WIDTH=4 so saturation is reachable).
// Works in both the default build and with PIPE_SKID_EN defined.
// -----------------------------------------------------------------------------
module tb_pipe_reg_de;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  flush_i;
    logic                  valid_d_i;
    logic                  ready_d_o;
    logic [DW-1:0]         rd1_d_i, rd2_d_i, imm_ext_d_i;
    logic [AW-1:0]         pc_d_i, pc_plus4_d_i;
    logic [RW-1:0]         rd_addr_d_i;
    logic [CTRL_WIDTH-1:0] ctrl_d_i;
    logic                  valid_e_o;
    logic                  ready_e_i;
    logic [DW-1:0]         rd1_e_o, rd2_e_o, imm_ext_e_o;
    logic [AW-1:0]         pc_e_o, pc_plus4_e_o;
    logic [RW-1:0]         rd_addr_e_o;
    logic [CTRL_WIDTH-1:0] ctrl_e_o;
    logic [CW-1:0]         stall_cnt_o;

    int n_checks = 0;
    int n_passed = 0;

    localparam logic [CTRL_WIDTH-1:0] CTRL_ONES   = 11'h7FF;
    localparam logic [CTRL_WIDTH-1:0] CTRL_MASKED = 11'h31F; // ones minus side effects
    localparam logic [CTRL_WIDTH-1:0] CTRL_BRANCH = 11'h020;

    pipe_reg_de #(
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .REG_ADDR_WIDTH (RW),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .valid_d_i    (valid_d_i),
        .ready_d_o    (ready_d_o),
        .rd1_d_i      (rd1_d_i),
        .rd2_d_i      (rd2_d_i),
        .imm_ext_d_i  (imm_ext_d_i),
        .pc_d_i       (pc_d_i),
        .pc_plus4_d_i (pc_plus4_d_i),
        .rd_addr_d_i  (rd_addr_d_i),
        .ctrl_d_i     (ctrl_d_i),
        .valid_e_o    (valid_e_o),
        .ready_e_i    (ready_e_i),
        .rd1_e_o      (rd1_e_o),
        .rd2_e_o      (rd2_e_o),
        .imm_ext_e_o  (imm_ext_e_o),
        .pc_e_o       (pc_e_o),
        .pc_plus4_e_o (pc_plus4_e_o),
        .rd_addr_e_o  (rd_addr_e_o),
        .ctrl_e_o     (ctrl_e_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] pc, input logic [CTRL_WIDTH-1:0] c);
        valid_d_i    = v;
        pc_d_i       = pc;
        pc_plus4_d_i = pc + 32'd4;
        rd1_d_i      = pc + 32'd100;
        rd2_d_i      = pc + 32'd200;
        imm_ext_d_i  = pc + 32'd300;
        rd_addr_d_i  = pc[6:2];
        ctrl_d_i     = c;
    endtask

    initial begin
        rst_ni    = 1'b0;
        flush_i   = 1'b0;
        ready_e_i = 1'b0;
        drive(1'b1, 32'hFF, CTRL_ONES);

        // Reset / bubble
        tick(); tick();
        check_eq("rst_valid", {63'd0, valid_e_o}, 64'd0);
        check_eq("rst_ctrl", {53'd0, ctrl_e_o}, 64'd0);
        check_eq("rst_cnt", {60'd0, stall_cnt_o}, 64'd0);
        drive(1'b0, 32'h0, CTRL_ONES);
        rst_ni = 1'b1;
        tick();
        check_eq("post_rst_ready", {63'd0, ready_d_o}, 64'd1);
        check_eq("post_rst_valid", {63'd0, valid_e_o}, 64'd0);

        // Streaming
        ready_e_i = 1'b1;
        drive(1'b1, 32'h00, CTRL_ONES);
        tick();
        check_eq("stream_v0", {63'd0, valid_e_o}, 64'd1);
        check_eq("stream_pc0", {32'd0, pc_e_o}, 64'h00);
        drive(1'b1, 32'h04, CTRL_ONES);
        tick();
        check_eq("stream_pc1", {32'd0, pc_e_o}, 64'h04);
        drive(1'b1, 32'h08, CTRL_ONES);
        tick();
        check_eq("stream_pc2", {32'd0, pc_e_o}, 64'h08);
        check_eq("stream_v2", {63'd0, valid_e_o}, 64'd1);
        check_eq("stream_pc4", {32'd0, pc_plus4_e_o}, 64'h0C);
        check_eq("stream_rd1", {32'd0, rd1_e_o}, 64'd108);
        check_eq("stream_imm", {32'd0, imm_ext_e_o}, 64'd308);
        check_eq("stream_ctrl", {53'd0, ctrl_e_o}, {53'd0, CTRL_ONES});
        drive(1'b0, 32'h0, 11'h000);
        tick();
        check_eq("drain_valid", {63'd0, valid_e_o}, 64'd0);
        check_eq("bubble_ctrl", {53'd0, ctrl_e_o}, {53'd0, CTRL_MASKED});

        // Stall
        drive(1'b1, 32'h10, 11'h000);
        tick();
        check_eq("stall_pre_pc", {32'd0, pc_e_o}, 64'h10);
        ready_e_i = 1'b0;
        drive(1'b1, 32'h14, 11'h000);
        #1;
`ifdef PIPE_SKID_EN
        check_eq("stall_ready_first", {63'd0, ready_d_o}, 64'd1);
`else
        check_eq("stall_ready_first", {63'd0, ready_d_o}, 64'd0);
`endif
        for (int i = 1; i <= 3; i++) begin
            tick();
`ifdef PIPE_SKID_EN
            if (i == 1) valid_d_i = 1'b0;
`endif
            check_eq("stall_pc", {32'd0, pc_e_o}, 64'h10);
            check_eq("stall_cnt", {60'd0, stall_cnt_o}, i);
            check_eq("stall_ready", {63'd0, ready_d_o}, 64'd0);
        end
        ready_e_i = 1'b1;
        tick();
        valid_d_i = 1'b0;
        check_eq("after_stall_pc", {32'd0, pc_e_o}, 64'h14);
        check_eq("after_stall_v", {63'd0, valid_e_o}, 64'd1);
        tick();
        check_eq("once_only", {63'd0, valid_e_o}, 64'd0);
        check_eq("stall_cnt_hold", {60'd0, stall_cnt_o}, 64'd3);

        // Flush (while E is also stalled: flush must win)
        drive(1'b1, 32'h18, CTRL_BRANCH);
        tick();
        check_eq("flush_pre_ctrl", {53'd0, ctrl_e_o}, {53'd0, CTRL_BRANCH});
        ready_e_i = 1'b0;
        flush_i   = 1'b1;
        drive(1'b1, 32'h20, CTRL_ONES);
        tick();
        check_eq("flush_valid", {63'd0, valid_e_o}, 64'd0);
        check_eq("flush_ctrl", {53'd0, ctrl_e_o}, 64'd0);
        check_eq("flush_no_cnt", {60'd0, stall_cnt_o}, 64'd3);
        flush_i   = 1'b0;
        ready_e_i = 1'b1;
        drive(1'b0, 32'h0, 11'h000);
        tick();
        check_eq("flush_still_empty", {63'd0, valid_e_o}, 64'd0);
        check_eq("flush_pc_not_20", {32'd0, pc_e_o}, 64'h18);

        // Saturation
        drive(1'b1, 32'h30, 11'h000);
        tick();
        drive(1'b0, 32'h0, 11'h000);
        ready_e_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_eq("sat_cnt", {60'd0, stall_cnt_o}, (3 + i > 15) ? 64'd15 : 64'(3 + i));
        end
        check_eq("sat_pc", {32'd0, pc_e_o}, 64'h30);

        // Async reset mid-stall (skid build parks 0x34 first)
        drive(1'b1, 32'h34, 11'h000);
        tick();
        drive(1'b0, 32'h0, 11'h000);
        #3;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, valid_e_o}, 64'd0);
        check_eq("arst_cnt", {60'd0, stall_cnt_o}, 64'd0);
        check_eq("arst_pc", {32'd0, pc_e_o}, 64'h0);
        #2;
        rst_ni    = 1'b1;
        ready_e_i = 1'b1;
        tick();
        tick();
        check_eq("arst_skid_empty", {63'd0, valid_e_o}, 64'd0);
        check_eq("arst_ready", {63'd0, ready_d_o}, 64'd1);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
